// File: rtl/ping_pong_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ping_pong_ctrl
//  Purpose  : Ping-pong buffer controller for two byte-enabled single-port
//             RAM banks. One bank fills with a FRAME_LEN-word frame from a
//             valid/ready input stream while the other bank drains to a
//             valid/ready output stream through a 2-entry skid FIFO.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid/in_ready/in_data     - input word stream
//             in_be                         - byte enables (PP_BYTE_EN_EN only)
//             out_valid/out_ready/out_data/out_last - output word stream
//             bankN_en/we/addr/din          - bank controls (en=1 write)
//             bankN_dout                    - bank read data (1-cycle latency)
//             bank_full                     - per-bank FULL-or-DRAINING flag
//  Options  : `define PP_BYTE_EN_EN adds the in_be port; otherwise every
//             accepted word writes all bytes.
//  Revision : 1.0 - initial release
// ============================================================================
module ping_pong_ctrl #(
    parameter int WIDTH      = 32,
    parameter int WE_WIDTH   = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int FRAME_LEN  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
`ifdef PP_BYTE_EN_EN
    input  logic [WE_WIDTH-1:0]   in_be,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic                  bank0_en,
    output logic [WE_WIDTH-1:0]   bank0_we,
    output logic [ADDR_WIDTH-1:0] bank0_addr,
    output logic [WIDTH-1:0]      bank0_din,
    input  logic [WIDTH-1:0]      bank0_dout,
    output logic                  bank1_en,
    output logic [WE_WIDTH-1:0]   bank1_we,
    output logic [ADDR_WIDTH-1:0] bank1_addr,
    output logic [WIDTH-1:0]      bank1_din,
    input  logic [WIDTH-1:0]      bank1_dout,
    output logic [1:0]            bank_full
);

    // Per-bank state encoding; bit 1 set means the bank holds a frame.
    localparam logic [1:0] c_EMPTY    = 2'd0;
    localparam logic [1:0] c_FILLING  = 2'd1;
    localparam logic [1:0] c_FULL     = 2'd2;
    localparam logic [1:0] c_DRAINING = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

    logic [1:0]            r_state [2];
    logic [1:0]            w_state_nxt [2];
    logic                  r_wr_bank;
    logic                  r_rd_bank;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH-1:0] r_bank0_addr;
    logic [ADDR_WIDTH-1:0] r_bank1_addr;

    // Read issued last cycle; its data appears on the bank dout this cycle.
    logic                  r_inflight;
    logic                  r_inflight_bank;
    logic                  r_inflight_last;

    // Two-entry skid FIFO holding read data the consumer has not yet taken.
    logic [WIDTH-1:0]      r_fifo_data [2];
    logic                  r_fifo_last [2];
    logic                  r_fifo_wptr;
    logic                  r_fifo_rptr;
    logic [1:0]            r_fifo_count;

    logic                  w_wr_fire;
    logic                  w_rd_avail;
    logic                  w_rd_fire;
    logic                  w_pop;
    logic                  w_fifo_empty;
    logic                  w_push;
    logic                  w_fifo_pop;
    logic [1:0]            w_occupancy;
    logic [WIDTH-1:0]      w_cap_data;
    logic [WE_WIDTH-1:0]   w_wr_be;

`ifdef PP_BYTE_EN_EN
    assign w_wr_be = in_be;
`else
    assign w_wr_be = {WE_WIDTH{1'b1}};
`endif

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign in_ready  = (r_state[r_wr_bank] == c_EMPTY) || (r_state[r_wr_bank] == c_FILLING);
    assign w_wr_fire = in_valid & in_ready;

    assign w_fifo_empty = (r_fifo_count == 2'd0);
    // The in-flight word is presented directly from the bank while the FIFO
    // is empty, so a frame's first word is visible two cycles after its last
    // write.
    assign w_cap_data = r_inflight_bank ? bank1_dout : bank0_dout;
    assign out_valid  = ~w_fifo_empty | r_inflight;
    assign out_data   = w_fifo_empty ? w_cap_data      : r_fifo_data[r_fifo_rptr];
    assign out_last   = w_fifo_empty ? r_inflight_last : r_fifo_last[r_fifo_rptr];
    assign w_pop      = out_valid & out_ready;

    // Words owed to the consumer: stored entries plus the one in flight.
    // A pop this cycle frees a slot, which keeps a 1-word/cycle drain.
    assign w_occupancy = r_fifo_count + {1'b0, r_inflight};
    assign w_rd_avail  = (r_state[r_rd_bank] == c_FULL) || (r_state[r_rd_bank] == c_DRAINING);
    assign w_rd_fire   = w_rd_avail & ((w_occupancy < 2'd2) | w_pop);

    // An in-flight word consumed straight from the bank never enters the FIFO.
    assign w_push     = r_inflight & ~(w_fifo_empty & out_ready);
    assign w_fifo_pop = w_pop & ~w_fifo_empty;

    assign bank_full[0] = r_state[0][1];
    assign bank_full[1] = r_state[1][1];

    // ------------------------------------------------------------------
    // Bank state transitions. Writer and reader always target different
    // banks (EMPTY/FILLING vs FULL/DRAINING), so both may update at once.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt[0] = r_state[0];
        w_state_nxt[1] = r_state[1];
        if (w_wr_fire) begin
            w_state_nxt[r_wr_bank] = (r_wr_addr == c_LAST_ADDR) ? c_FULL : c_FILLING;
        end
        if (w_rd_fire) begin
            w_state_nxt[r_rd_bank] = (r_rd_addr == c_LAST_ADDR) ? c_EMPTY : c_DRAINING;
        end
    end

    // ------------------------------------------------------------------
    // Bank port drive; an idle bank keeps its previous address.
    // ------------------------------------------------------------------
    always_comb begin
        bank0_en   = 1'b0;
        bank0_we   = '0;
        bank0_addr = r_bank0_addr;
        bank0_din  = '0;
        bank1_en   = 1'b0;
        bank1_we   = '0;
        bank1_addr = r_bank1_addr;
        bank1_din  = '0;
        if (w_wr_fire) begin
            if (r_wr_bank == 1'b0) begin
                bank0_en   = 1'b1;
                bank0_we   = w_wr_be;
                bank0_addr = r_wr_addr;
                bank0_din  = in_data;
            end else begin
                bank1_en   = 1'b1;
                bank1_we   = w_wr_be;
                bank1_addr = r_wr_addr;
                bank1_din  = in_data;
            end
        end
        if (w_rd_fire) begin
            if (r_rd_bank == 1'b0) begin
                bank0_addr = r_rd_addr;
            end else begin
                bank1_addr = r_rd_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state[0]      <= c_EMPTY;
            r_state[1]      <= c_EMPTY;
            r_wr_bank       <= 1'b0;
            r_rd_bank       <= 1'b0;
            r_wr_addr       <= '0;
            r_rd_addr       <= '0;
            r_bank0_addr    <= '0;
            r_bank1_addr    <= '0;
            r_inflight      <= 1'b0;
            r_inflight_bank <= 1'b0;
            r_inflight_last <= 1'b0;
            r_fifo_wptr     <= 1'b0;
            r_fifo_rptr     <= 1'b0;
            r_fifo_count    <= 2'd0;
        end else begin
            r_state[0]   <= w_state_nxt[0];
            r_state[1]   <= w_state_nxt[1];
            r_bank0_addr <= bank0_addr;
            r_bank1_addr <= bank1_addr;

            if (w_wr_fire) begin
                if (r_wr_addr == c_LAST_ADDR) begin
                    r_wr_addr <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_addr <= r_wr_addr + 1'b1;
                end
            end

            if (w_rd_fire) begin
                if (r_rd_addr == c_LAST_ADDR) begin
                    r_rd_addr <= '0;
                    r_rd_bank <= ~r_rd_bank;
                end else begin
                    r_rd_addr <= r_rd_addr + 1'b1;
                end
            end

            r_inflight      <= w_rd_fire;
            r_inflight_bank <= r_rd_bank;
            r_inflight_last <= (r_rd_addr == c_LAST_ADDR);

            if (w_push) begin
                r_fifo_wptr <= ~r_fifo_wptr;
            end
            if (w_fifo_pop) begin
                r_fifo_rptr <= ~r_fifo_rptr;
            end
            r_fifo_count <= r_fifo_count + {1'b0, w_push} - {1'b0, w_fifo_pop};
        end
    end

    // FIFO storage needs no reset; entries are only read once counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_fifo_wptr] <= w_cap_data;
            r_fifo_last[r_fifo_wptr] <= r_inflight_last;
        end
    end

endmodule
`default_nettype wire
